// File: rtl/turn_dealer.sv
// turn_dealer: keypad-driven card dealer and turn rotator for 2..8 players.
// In: clk, rst, keypad_in, finish. Out: whose, turn_pulse, turn_count, card_*.
// Define TURN_DEALER_REVERSE_EN to enable key 4'b0100 reversing rotation.
module turn_dealer #(
  parameter int         NUM_PLAYERS = 2,
  parameter int         CNT_W       = 8,
  parameter logic [4:0] LFSR_SEED   = 5'b11100,
  parameter int         MAX_DRAW    = 3,
  parameter logic [3:0] KEY_DRAW    = 4'b0010,
  parameter logic [3:0] KEY_END     = 4'b0011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       keypad_in,
  input  logic             finish,
  output logic [2:0]       whose,
  output logic             turn_pulse,
  output logic [CNT_W-1:0] turn_count,
  output logic             card_valid,
  output logic [1:0]       card_color,
  output logic [2:0]       card_number,
  output logic [2:0]       card_player
);

  localparam logic [2:0] LAST = 3'(NUM_PLAYERS - 1);
  localparam logic [2:0] MAXD = 3'(MAX_DRAW);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEAL,
    S_PASS
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] prev_key;
  logic [4:0] lfsr;
  logic [2:0] draws;
  logic       accept;
  logic       deal_go;
  logic       pass_go;
  logic [1:0] col_m;
  logic [2:0] num_m;
  logic [2:0] whose_inc;
  logic [2:0] whose_nxt;

  // Only the first cycle of a press counts.
  assign accept = (keypad_in != 4'b0000) && (prev_key == 4'b0000);

  assign col_m = (lfsr[4:3] == 2'd3) ? 2'd0 : lfsr[4:3];
  assign num_m = (lfsr[2:0] >= 3'd5) ? lfsr[2:0] - 3'd5 : lfsr[2:0];

  assign whose_inc = (whose == LAST) ? 3'd0 : whose + 3'd1;

`ifdef TURN_DEALER_REVERSE_EN
  logic       dir;
  logic       rev_go;
  logic [2:0] whose_dec;

  assign whose_dec = (whose == 3'd0) ? LAST : whose - 3'd1;
  assign whose_nxt = dir ? whose_dec : whose_inc;
`else
  assign whose_nxt = whose_inc;
`endif

  // Strobes follow the one-cycle states directly.
  assign card_valid = (state == S_DEAL);
  assign turn_pulse = (state == S_PASS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = S_IDLE;
    deal_go   = 1'b0;
    pass_go   = 1'b0;
`ifdef TURN_DEALER_REVERSE_EN
    rev_go    = 1'b0;
`endif
    if (!finish && state == S_IDLE && accept) begin
      if (keypad_in == KEY_DRAW && draws < MAXD) begin
        deal_go   = 1'b1;
        state_nxt = S_DEAL;
      end else if (keypad_in == KEY_END) begin
        pass_go   = 1'b1;
        state_nxt = S_PASS;
`ifdef TURN_DEALER_REVERSE_EN
      end else if (keypad_in == 4'b0100) begin
        rev_go    = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_key    <= 4'b0000;
      lfsr        <= LFSR_SEED;
      whose       <= 3'd0;
      turn_count  <= '0;
      draws       <= 3'd0;
      card_color  <= 2'd0;
      card_number <= 3'd0;
      card_player <= 3'd0;
    end else begin
      prev_key <= keypad_in;
      // A stuck-at-zero state would never leave zero; reseed instead.
      if (lfsr == 5'd0) begin
        lfsr <= LFSR_SEED;
      end else begin
        lfsr <= {lfsr[3:0], lfsr[4] ^ lfsr[2]};
      end
      if (finish) begin
        whose      <= 3'd0;
        turn_count <= '0;
        draws      <= 3'd0;
      end else begin
        if (deal_go) begin
          draws       <= draws + 3'd1;
          card_color  <= col_m + 2'd1;
          card_number <= num_m + 3'd1;
          card_player <= whose;
        end
        if (pass_go) begin
          whose      <= whose_nxt;
          turn_count <= turn_count + CNT_W'(1);
          draws      <= 3'd0;
        end
      end
    end
  end

`ifdef TURN_DEALER_REVERSE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dir <= 1'b0;
    end else if (finish) begin
      dir <= 1'b0;
    end else if (rev_go) begin
      dir <= ~dir;
    end
  end
`endif

endmodule

// File: tb/tb_turn_dealer.sv
// tb_turn_dealer: random and directed stimulus for turn_dealer,
// checked every cycle against a behavioural model.
module tb_turn_dealer;

  localparam int         NP   = 3;
  localparam int         CW   = 8;
  localparam int         MAXD = 3;
  localparam logic [4:0] SEED = 5'b11100;
  localparam logic [3:0] KD   = 4'b0010;
  localparam logic [3:0] KE   = 4'b0011;
  localparam logic [3:0] KR   = 4'b0100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    keypad_in = 4'b0000;
  logic          finish = 1'b0;
  logic [2:0]    whose;
  logic          turn_pulse;
  logic [CW-1:0] turn_count;
  logic          card_valid;
  logic [1:0]    card_color;
  logic [2:0]    card_number;
  logic [2:0]    card_player;

  turn_dealer #(
    .NUM_PLAYERS(NP),
    .CNT_W(CW),
    .LFSR_SEED(SEED),
    .MAX_DRAW(MAXD),
    .KEY_DRAW(KD),
    .KEY_END(KE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .keypad_in(keypad_in),
    .finish(finish),
    .whose(whose),
    .turn_pulse(turn_pulse),
    .turn_count(turn_count),
    .card_valid(card_valid),
    .card_color(card_color),
    .card_number(card_number),
    .card_player(card_player)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int n_cards = 0;
  int n_pulses = 0;

  // Behavioural model: phase 0 idle, 1 dealing, 2 passing.
  int m_lfsr, m_prev, m_phase, m_whose, m_cnt, m_draws;
  int m_col, m_num, m_ply, m_dir;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic [3:0] k, input logic f,
                            input logic r);
    int  q;
    int  ph;
    bit  acc;
    if (r) begin
      m_lfsr = SEED; m_prev = 0; m_phase = 0; m_whose = 0;
      m_cnt = 0; m_draws = 0; m_col = 0; m_num = 0;
      m_ply = 0; m_dir = 0;
      return;
    end
    q   = m_lfsr;
    ph  = m_phase;
    acc = (k != 0) && (m_prev == 0);
    m_phase = 0;
    if (f) begin
      m_whose = 0; m_cnt = 0; m_draws = 0; m_dir = 0;
    end else if (acc && ph == 0) begin
      if (k == KD && m_draws < MAXD) begin
        m_phase = 1;
        m_draws++;
        m_col = (q / 8) % 3 + 1;
        m_num = (q % 8) % 5 + 1;
        m_ply = m_whose;
      end else if (k == KE) begin
        m_phase = 2;
        if (m_dir != 0) m_whose = (m_whose + NP - 1) % NP;
        else m_whose = (m_whose + 1) % NP;
        m_cnt = (m_cnt + 1) % (1 << CW);
        m_draws = 0;
`ifdef TURN_DEALER_REVERSE_EN
      end else if (k == KR) begin
        m_dir = 1 - m_dir;
`endif
      end
    end
    if (q == 0) m_lfsr = SEED;
    else m_lfsr = ((q * 2) % 32) | (((q >> 4) ^ (q >> 2)) & 1);
    m_prev = k;
  endtask

  task automatic cyc(input logic [3:0] k, input logic f, input logic r);
    keypad_in = k;
    finish    = f;
    rst       = r;
    @(posedge clk);
    model_step(k, f, r);
    @(negedge clk);
    check("whose", whose, m_whose);
    check("turn_pulse", turn_pulse, m_phase == 2);
    check("turn_count", turn_count, m_cnt);
    check("card_valid", card_valid, m_phase == 1);
    check("card_color", card_color, m_col);
    check("card_number", card_number, m_num);
    check("card_player", card_player, m_ply);
    if (card_valid === 1'b1) n_cards++;
    if (turn_pulse === 1'b1) n_pulses++;
  endtask

  task automatic press(input logic [3:0] k, input int hold);
    for (int i = 0; i < hold; i++) cyc(k, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0000, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] ktab [6];
    logic [3:0] k;
    int         hold;
    ktab[0] = 4'b0000; ktab[1] = KD; ktab[2] = KE;
    ktab[3] = KR;      ktab[4] = 4'b0111; ktab[5] = KD;

    do_reset();
    check("rst_whose", whose, 0);
    check("rst_count", turn_count, 0);
    check("rst_valid", card_valid, 0);
    check("rst_color", card_color, 0);

    cyc(KD, 1'b0, 1'b0);
    check("deal_valid", card_valid, 1);
    check("deal_player", card_player, 0);
    cyc(4'b0000, 1'b0, 1'b0);
    check("deal_once", card_valid, 0);

    do_reset();
    press(KE, 1);
    check("rot1", whose, 1);
    press(KE, 1);
    check("rot2", whose, 2);
    press(KE, 1);
    check("rot0", whose, 0);
    check("rot_count", turn_count, 3);

    do_reset();
    n_cards = 0;
    for (int i = 0; i < 4; i++) press(KD, 1);
    check("max_draw", n_cards, 3);
    press(KE, 1);
    n_cards = 0;
    press(KD, 1);
    check("draw_after_end", n_cards, 1);

    do_reset();
    n_pulses = 0;
    press(KE, 10);
    check("held_pulses", n_pulses, 1);
    check("held_whose", whose, 1);

    do_reset();
    for (int i = 0; i < 255; i++) press(KE, 1);
    check("count_255", turn_count, 255);
    press(KE, 1);
    check("count_wrap", turn_count, 0);
    press(KE, 1);
    n_pulses = 0;
    cyc(KE, 1'b1, 1'b0);
    check("fin_pulse", n_pulses, 0);
    check("fin_whose", whose, 0);
    check("fin_count", turn_count, 0);
    cyc(4'b0000, 1'b0, 1'b0);

    do_reset();
    press(KR, 1);
    press(KE, 1);
`ifdef TURN_DEALER_REVERSE_EN
    check("reverse", whose, NP - 1);
`else
    check("reverse", whose, 1);
`endif

    cyc(KD, 1'b0, 1'b1);
    check("rst_abandon", card_valid, 0);
    cyc(4'b0000, 1'b0, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      k    = ktab[$urandom_range(0, 5)];
      hold = $urandom_range(1, 3);
      for (int j = 0; j < hold; j++)
        cyc(k, ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));
      cyc(4'b0000, ($urandom_range(0, 31) == 0), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
